// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad row scanner with column synchronizer and press/release debounce
// Registered rows/columns stay non-zero exactly while a debounced key is held; key_valid pulses once per press.
module keypad_scanner #(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_in_n,
  output logic [3:0] row_drive_n,
  output logic [3:0] rows,
  output logic [3:0] columns,
  output logic       key_valid
);

  localparam int DW = $clog2(SCAN_DIV) + 1;
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    r, r_nxt;
  logic [DW-1:0] dwell, dwell_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    sync1, sync2;
  logic [3:0]    cand, cand_nxt;
  logic [3:0]    rows_nxt, columns_nxt;
  logic          key_valid_nxt;

  logic [3:0]    col_s;
  logic [3:0]    r_adv;
  logic          col_onehot;
  logic          cand_hit;

  assign row_drive_n = ~r;
  assign col_s       = ~sync2;
  assign r_adv       = {r[2:0], r[3]};
  assign col_onehot  = (col_s != 4'd0) && ((col_s & (col_s - 4'd1)) == 4'd0);
  // Once a key is held, only its own column matters; other keys are ignored.
  assign cand_hit    = |(col_s & cand);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCAN;
      r         <= 4'b0001;
      dwell     <= '0;
      cnt       <= '0;
      sync1     <= 4'hF;
      sync2     <= 4'hF;
      cand      <= 4'd0;
      rows      <= 4'd0;
      columns   <= 4'd0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      r         <= r_nxt;
      dwell     <= dwell_nxt;
      cnt       <= cnt_nxt;
      sync1     <= col_in_n;
      sync2     <= sync1;
      cand      <= cand_nxt;
      rows      <= rows_nxt;
      columns   <= columns_nxt;
      key_valid <= key_valid_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    r_nxt         = r;
    dwell_nxt     = dwell;
    cnt_nxt       = cnt;
    cand_nxt      = cand;
    rows_nxt      = rows;
    columns_nxt   = columns;
    key_valid_nxt = 1'b0;

    case (state)
      SCAN: begin
        // Sample only at the end of the dwell so the synchronizer has settled on this row.
        if (dwell == DWELL_LAST) begin
          dwell_nxt = '0;
          if (col_onehot) begin
            cand_nxt  = col_s;
            cnt_nxt   = '0;
            state_nxt = DEBOUNCE;
          end else begin
            r_nxt = r_adv;
          end
        end else begin
          dwell_nxt = dwell + DW'(1);
        end
      end

      DEBOUNCE: begin
        if (col_s == cand) begin
          if (cnt == CNT_LAST) begin
            state_nxt     = PRESSED;
            rows_nxt      = r;
            columns_nxt   = cand;
            key_valid_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end else begin
          state_nxt = SCAN;
          r_nxt     = r_adv;
          dwell_nxt = '0;
        end
      end

      PRESSED: begin
        if (!cand_hit) begin
          cnt_nxt   = '0;
          state_nxt = RELEASE;
        end
      end

      RELEASE: begin
        if (cand_hit) begin
          state_nxt = PRESSED;
        end else if (cnt == CNT_LAST) begin
          rows_nxt    = 4'd0;
          columns_nxt = 4'd0;
          r_nxt       = r_adv;
          dwell_nxt   = '0;
          state_nxt   = SCAN;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      default: state_nxt = SCAN;
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed bench for keypad_scanner with key-matrix model and pulse scoreboard
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] col_in_n;
  logic [3:0] row_drive_n;
  logic [3:0] rows;
  logic [3:0] columns;
  logic       key_valid;

  logic [15:0] keys = 16'd0;
  logic [7:0]  exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          pulse_cnt = 0;
  bit          mon_en = 1'b0;
  logic [3:0]  prev_cols = 4'd0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .col_in_n   (col_in_n),
    .row_drive_n(row_drive_n),
    .rows       (rows),
    .columns    (columns),
    .key_valid  (key_valid)
  );

  always #5 clk = ~clk;

  // Key (r,c) pulls column c low while row r is driven.
  always_comb begin
    col_in_n = 4'hF;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (keys[rr*4+cc] && !row_drive_n[rr]) col_in_n[cc] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (key_valid) begin
        pulse_cnt++;
        check("pulse_edge_prev_cols", {28'd0, prev_cols}, 32'd0);
        if (exp_q.size() == 0) check("unexpected_pulse", {31'd0, key_valid}, 32'd0);
        else check("pulse_rowcol", {24'd0, rows, columns}, {24'd0, exp_q.pop_front()});
      end
      check("inv_rowcol", {31'd0, ((rows == 4'd0) && (columns == 4'd0)) ||
                                  ($onehot(rows) && $onehot(columns))}, 32'd1);
      prev_cols = columns;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_pulse(input string tag, input int budget);
    int n0;
    int k;
    n0 = pulse_cnt;
    k = 0;
    while (pulse_cnt == n0 && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, pulse_cnt - n0, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_row_drive"}, {28'd0, row_drive_n}, 32'hE);
    check({tag, "_rows"}, {28'd0, rows}, 32'd0);
    check({tag, "_columns"}, {28'd0, columns}, 32'd0);
    check({tag, "_key_valid"}, {31'd0, key_valid}, 32'd0);
  endtask

  initial begin
    int n0;
    int k;
    logic [3:0] rd;

    // Reset and free-running scan
    reset = 1'b1;
    tick(3);
    mon_en = 1'b1;
    check_reset_vals("reset");
    reset = 1'b0;
    tick(3);
    check("scan_hold_row0", {28'd0, row_drive_n}, 32'hE);
    tick(1);
    check("scan_row1", {28'd0, row_drive_n}, 32'hD);
    tick(4);
    check("scan_row2", {28'd0, row_drive_n}, 32'hB);
    tick(4);
    check("scan_row3", {28'd0, row_drive_n}, 32'h7);
    tick(4);
    check("scan_wrap_row0", {28'd0, row_drive_n}, 32'hE);

    // Clean press of (2,1), held 100 cycles
    n0 = pulse_cnt;
    exp_q.push_back({4'b0100, 4'b0010});
    keys[2*4+1] = 1'b1;
    wait_pulse("clean_pulse", 40);
    tick(60);
    check("clean_rows_held", {28'd0, rows}, 32'h4);
    check("clean_cols_held", {28'd0, columns}, 32'h2);
    check("clean_single_pulse", pulse_cnt - n0, 1);
    keys = 16'd0;
    tick(10);
    check("clean_cols_before_release", {28'd0, columns}, 32'h2);
    tick(1);
    check("clean_cols_released", {28'd0, columns}, 32'h0);
    check("clean_rows_released", {28'd0, rows}, 32'h0);

    // Press bounce on (1,3)
    n0 = pulse_cnt;
    for (int i = 0; i < 20; i++) begin
      if (i % 3 == 0) keys[1*4+3] = ~keys[1*4+3];
      tick(1);
    end
    check("bounce_no_pulse", pulse_cnt - n0, 0);
    keys[1*4+3] = 1'b1;
    exp_q.push_back({4'b0010, 4'b1000});
    wait_pulse("bounce_pulse", 50);
    keys = 16'd0;
    tick(12);
    check("bounce_cols_released", {28'd0, columns}, 32'h0);

    // Release bounce on (3,0)
    n0 = pulse_cnt;
    exp_q.push_back({4'b1000, 4'b0001});
    keys[3*4+0] = 1'b1;
    wait_pulse("relb_pulse", 40);
    tick(5);
    keys = 16'd0;
    tick(4);
    keys[3*4+0] = 1'b1;
    tick(5);
    keys = 16'd0;
    tick(10);
    check("relb_cols_held", {28'd0, columns}, 32'h1);
    tick(1);
    check("relb_cols_released", {28'd0, columns}, 32'h0);
    check("relb_single_pulse", pulse_cnt - n0, 1);

    // Two columns on row 0, then a second key while (0,0) is held
    n0 = pulse_cnt;
    keys = 16'h0003;
    tick(36);
    rd = row_drive_n;
    tick(4);
    check("multi_scan_moving", {31'd0, rd != row_drive_n}, 32'd1);
    check("multi_no_pulse", pulse_cnt - n0, 0);
    check("multi_cols_zero", {28'd0, columns}, 32'h0);
    keys = 16'd0;
    tick(4);
    n0 = pulse_cnt;
    exp_q.push_back({4'b0001, 4'b0001});
    keys[0] = 1'b1;
    wait_pulse("second_first_pulse", 40);
    keys[15] = 1'b1;
    tick(40);
    check("second_rows_held", {28'd0, rows}, 32'h1);
    check("second_cols_held", {28'd0, columns}, 32'h1);
    check("second_no_extra_pulse", pulse_cnt - n0, 1);
    keys = 16'd0;
    tick(12);

    // Reset during DEBOUNCE on (1,2)
    k = 0;
    while (row_drive_n !== 4'b1110 && k < 20) begin
      tick(1);
      k++;
    end
    n0 = pulse_cnt;
    keys[1*4+2] = 1'b1;
    k = 0;
    while (row_drive_n !== 4'b1101 && k < 10) begin
      tick(1);
      k++;
    end
    check("rstdeb_row1_reached", {28'd0, row_drive_n}, 32'hD);
    tick(6);
    reset = 1'b1;
    tick(1);
    check_reset_vals("rstdeb");
    reset = 1'b0;
    check("rstdeb_no_pulse", pulse_cnt - n0, 0);
    exp_q.push_back({4'b0010, 4'b0100});
    wait_pulse("rstdeb_repulse", 50);

    // Reset during PRESSED, key still held
    tick(5);
    reset = 1'b1;
    tick(1);
    check_reset_vals("rstprs");
    reset = 1'b0;
    exp_q.push_back({4'b0010, 4'b0100});
    wait_pulse("rstprs_repulse", 50);
    keys = 16'd0;
    tick(12);
    check("rstprs_cols_released", {28'd0, columns}, 32'h0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
